// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-requester round-robin arbiter with a registered one-hot grant held until release.
// Optional forced revoke after MAX_HOLD cycles is built only when ARB_TIMEOUT_EN is defined.
module rr_arbiter_16 #(
    parameter int MAX_HOLD = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_i,
    input  logic        release_i,
    output logic [15:0] gnt_o,
    output logic        gnt_valid_o,
    output logic        timeout_o
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("rr_arbiter_16: MAX_HOLD must be >= 1");
    end

    state_t      state_q, state_d;
    logic [15:0] gnt_q, gnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  owner_q, owner_d;
    logic        timeout_q, timeout_d;
    logic [31:0] req_rot;
    logic [3:0]  offset;
    logic [3:0]  winner;
    logic        expire;
    logic        owner_done;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_q, hold_d;

    assign expire = hold_q == CW'(MAX_HOLD - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE) hold_d = '0;
        else if (!owner_done) hold_d = hold_q + 1'b1;
    end
`else
    assign expire = 1'b0;
`endif

    // Rotating by ptr makes the lowest set bit of req_rot the next winner in round-robin order.
    always_comb begin
        req_rot = {req_i, req_i} >> ptr_q;
        offset  = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (req_rot[i]) offset = 4'(i);
        winner = ptr_q + offset;
    end

    assign owner_done = release_i || !req_i[owner_q] || expire;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (|req_i) begin
                state_d = GRANT;
                owner_d = winner;
                gnt_d   = 16'd1 << winner;
            end
        end else if (owner_done) begin
            state_d   = IDLE;
            gnt_d     = 16'd0;
            ptr_d     = owner_q + 4'd1;
            timeout_d = expire && !release_i && req_i[owner_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 16'd0;
            ptr_q     <= 4'd0;
            owner_q   <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign timeout_o   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: directed and randomized checks of rr_arbiter_16 against a behavioural round-robin model.
module tb_rr_arbiter_16;
`ifdef ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MAX_HOLD = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = 16'd0;
    logic        rel = 1'b0;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_hold = 0;
    bit m_to = 1'b0;

    rr_arbiter_16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_i(req),
        .release_i(rel),
        .gnt_o(gnt),
        .gnt_valid_o(gnt_valid),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_gnt();
        return m_busy ? (16'd1 << m_owner) : 16'd0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_hold = 0; m_to = 1'b0;
    endtask

    // Behavioural view: search from ptr with modular arithmetic, hold until release/drop/timeout.
    task automatic model_edge(input logic [15:0] r, input logic rl);
        m_to = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 16; k++) begin
                if (!m_busy && r[(m_ptr + k) % 16]) begin
                    m_busy = 1'b1; m_owner = (m_ptr + k) % 16; m_hold = 0;
                end
            end
        end else if (rl || !r[m_owner] || (TO_EN && m_hold == MAX_HOLD - 1)) begin
            m_to = TO_EN && !rl && r[m_owner] && m_hold == MAX_HOLD - 1;
            m_busy = 1'b0;
            m_ptr = (m_owner + 1) % 16;
        end else begin
            m_hold++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".gnt"}, gnt, m_gnt());
        check({tag, ".valid"}, {15'd0, gnt_valid}, {15'd0, m_busy});
        check({tag, ".timeout"}, {15'd0, timeout}, {15'd0, m_to});
        check({tag, ".onehot0"}, {15'd0, $onehot0(gnt)}, 16'd1);
    endtask

    task automatic step(input logic [15:0] r, input logic rl, input string tag);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        model_edge(r, rl);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("reset");
        req = 16'd0;
        rel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] r;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(16'h0000, 1'b0, "idle");
            check("idle.const", gnt, 16'h0000);
        end
        step(16'h0001, 1'b0, "t2.grant");
        check("t2.const", gnt, 16'h0001);
        step(16'h0001, 1'b1, "t2.release");
        check("t2.rel_const", gnt, 16'h0000);
        step(16'h0003, 1'b0, "t2.ptr1");
        check("t2.ptr1_const", gnt, 16'h0002);
        step(16'h0000, 1'b0, "t2.drop");
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            step(16'hFFFF, 1'b0, "t3.grant");
            check("t3.seq", gnt, 16'd1 << (i % 16));
            step(16'hFFFF, 1'b1, "t3.release");
            check("t3.gap", gnt, 16'h0000);
        end
        step(16'h0010, 1'b0, "t4.g4");
        step(16'h0010, 1'b1, "t4.r4");
        step(16'h0011, 1'b0, "t4.wrap");
        check("t4.wrap_const", gnt, 16'h0001);
        step(16'h0011, 1'b1, "t4.r0");
        step(16'h0011, 1'b0, "t4.next");
        check("t4.next_const", gnt, 16'h0010);
        step(16'h0000, 1'b0, "t4.drop");
        step(16'h0080, 1'b0, "t5.g7");
        step(16'hFFFF, 1'b0, "t5.nopreempt");
        check("t5.hold_const", gnt, 16'h0080);
        step(16'hFF7F, 1'b0, "t5.reqdrop");
        check("t5.drop_const", gnt, 16'h0000);
        step(16'h0080, 1'b0, "t5.regrant");
        do_reset();
        check("t5.async_const", gnt, 16'h0000);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step(16'h0008, 1'b0, "t6.hold");
            check("t6.hold_const", gnt, 16'h0008);
        end
        step(16'h0008, 1'b0, "t6.expire");
        check("t6.exp_gnt", gnt, 16'h0000);
        check("t6.exp_to", {15'd0, timeout}, 16'd1);
        step(16'h0008, 1'b0, "t6.regrant");
        check("t6.regrant_const", gnt, 16'h0008);
        do_reset();
`endif
        r = 16'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = 16'($urandom) & 16'($urandom);
            step(r, $urandom_range(4) == 0, "rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
